// File: rtl/writeback_arbiter.sv
// Writeback stage owning the single register-file write port.
// Merges ALU results with buffered in-order load responses under a starvation bound.
module writeback_arbiter #(
    parameter int XLEN         = 32,
    parameter int LQ_DEPTH     = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        alu_valid,
    input  logic [4:0]                  alu_rd,
    input  logic [XLEN-1:0]             alu_data,
    output logic                        alu_stall,
    input  logic                        lsu_valid,
    output logic                        lsu_ready,
    input  logic [4:0]                  lsu_rd,
    input  logic [XLEN-1:0]             lsu_data,
    output logic                        rf_write_en,
    output logic [4:0]                  rf_write_addr,
    output logic [XLEN-1:0]             rf_write_data,
    input  logic [4:0]                  chk_addr,
    output logic                        chk_pending,
    output logic [$clog2(LQ_DEPTH):0]   lq_count
);

    localparam int PW = $clog2(LQ_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(LQ_DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    logic [4:0]          q_rd   [LQ_DEPTH];
    logic [XLEN-1:0]     q_data [LQ_DEPTH];
    logic [LQ_DEPTH-1:0] q_vld;
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic [CW-1:0]       count;
    logic [SW-1:0]       starve;

    logic force_drain;
    logic alu_win;
    logic pop;
    logic push;
    logic hit;

    assign force_drain = (count != '0) && (starve == LIMIT_C);
    assign alu_win     = alu_valid && !force_drain;
    assign pop         = reset_n && !alu_win && (count != '0);
    assign lsu_ready   = reset_n && (count < DEPTH_C);
    assign push        = lsu_valid && lsu_ready;
    assign alu_stall   = reset_n && alu_valid && force_drain;
    assign lq_count    = count;

    // Incoming same-cycle push is deliberately not visible to the hazard query.
    always_comb begin
        hit = rf_write_en && (rf_write_addr == chk_addr);
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (q_vld[i] && (q_rd[i] == chk_addr)) hit = 1'b1;
        end
        chk_pending = (chk_addr != 5'd0) && hit;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= lsu_rd;
            q_data[wr_ptr] <= lsu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            starve        <= '0;
            q_vld         <= '0;
            rf_write_en   <= 1'b0;
            rf_write_addr <= '0;
            rf_write_data <= '0;
        end else begin
            if (push) begin
                q_vld[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (alu_win) begin
                rf_write_en   <= (alu_rd != 5'd0);
                rf_write_addr <= alu_rd;
                rf_write_data <= alu_data;
                starve        <= (count != '0) ? starve + 1'b1 : '0;
            end else if (count != '0) begin
                // x0 loads still consume their entry but never reach the RF.
                rf_write_en   <= (q_rd[rd_ptr] != 5'd0);
                rf_write_addr <= q_rd[rd_ptr];
                rf_write_data <= q_data[rd_ptr];
                q_vld[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
                starve        <= '0;
            end else begin
                rf_write_en   <= 1'b0;
                starve        <= '0;
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: expected RF writes go into a scoreboard
// queue, a negedge monitor pops and compares whenever rf_write_en is seen.
module tb_writeback_arbiter;

    logic        clk;
    logic        reset_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        rf_write_en;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic [4:0]  chk_addr;
    logic        chk_pending;
    logic [2:0]  lq_count;

    writeback_arbiter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .alu_stall     (alu_stall),
        .lsu_valid     (lsu_valid),
        .lsu_ready     (lsu_ready),
        .lsu_rd        (lsu_rd),
        .lsu_data      (lsu_data),
        .rf_write_en   (rf_write_en),
        .rf_write_addr (rf_write_addr),
        .rf_write_data (rf_write_data),
        .chk_addr      (chk_addr),
        .chk_pending   (chk_pending),
        .lq_count      (lq_count)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [4:0] rd, input logic [31:0] data);
        wr_t w;
        w.rd   = rd;
        w.data = data;
        exp_q.push_back(w);
    endtask

    // Monitor: every asserted write must match the oldest expected write.
    always @(negedge clk) begin
        if (rf_write_en === 1'b1) begin
            wr_t w;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr=%0d data=0x%0h expected no write",
                         rf_write_addr, rf_write_data);
            end else begin
                w = exp_q.pop_front();
                if (rf_write_addr !== w.rd || rf_write_data !== w.data) begin
                    fails++;
                    $display("FAIL rf_write: got addr=%0d data=0x%0h expected addr=%0d data=0x%0h",
                             rf_write_addr, rf_write_data, w.rd, w.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        alu_valid = 1'b1;
        alu_rd    = 5'd3;
        alu_data  = 32'h1;
        lsu_valid = 1'b1;
        lsu_rd    = 5'd4;
        lsu_data  = 32'h2;
        chk_addr  = 5'd0;

        // Reset held with both requesters active
        repeat (3) tick();
        check("rst_lsu_ready", 32'(lsu_ready), 32'd0);
        check("rst_alu_stall", 32'(alu_stall), 32'd0);
        check("rst_rf_write_en", 32'(rf_write_en), 32'd0);
        check("rst_lq_count", 32'(lq_count), 32'd0);
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        reset_n   = 1'b1;
        tick();

        // Single ALU write, empty queue
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 32'hDEADBEEF;
        #1;
        check("alu_stall_empty", 32'(alu_stall), 32'd0);
        push_exp(5'd5, 32'hDEADBEEF);
        tick();
        alu_valid = 1'b0;
        check("alu_wen_next", 32'(rf_write_en), 32'd1);
        tick();
        check("alu_wen_drop", 32'(rf_write_en), 32'd0);

        // Three back-to-back loads drain on consecutive cycles
        lsu_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            lsu_rd   = 5'(k);
            lsu_data = 32'(k * 17);
            push_exp(5'(k), 32'(k * 17));
            tick();
        end
        lsu_valid = 1'b0;
        check("ld3_wen", 32'(rf_write_en), 32'd1);
        check("ld3_count", 32'(lq_count), 32'd1);
        tick();
        check("ld3_wen_last", 32'(rf_write_en), 32'd1);
        check("ld3_count_empty", 32'(lq_count), 32'd0);
        repeat (2) tick();

        // x0 load is consumed silently
        lsu_valid = 1'b1;
        lsu_rd    = 5'd0;
        lsu_data  = 32'hFFFF;
        tick();
        lsu_valid = 1'b0;
        check("x0_count1", 32'(lq_count), 32'd1);
        tick();
        check("x0_count0", 32'(lq_count), 32'd0);
        check("x0_no_wen", 32'(rf_write_en), 32'd0);
        repeat (2) tick();

        // Starvation: ALU held high while four loads fill the queue
        alu_valid = 1'b1;
        alu_rd    = 5'd10;
        for (int k = 1; k <= 9; k++) begin
            alu_data = 32'hA00 + 32'(k);
            if (k <= 4) begin
                lsu_valid = 1'b1;
                lsu_rd    = 5'(10 + k);
                lsu_data  = 32'hB0 + 32'(k);
            end else begin
                lsu_valid = 1'b0;
            end
            push_exp(5'd10, 32'hA00 + 32'(k));
            tick();
            if (k == 4) begin
                check("starve_full_count", 32'(lq_count), 32'd4);
                check("starve_full_ready", 32'(lsu_ready), 32'd0);
            end
            if (k == 8) check("starve_not_yet", 32'(alu_stall), 32'd0);
        end
        lsu_valid = 1'b0;
        check("starve_stall", 32'(alu_stall), 32'd1);
        check("starve_count4", 32'(lq_count), 32'd4);
        push_exp(5'd11, 32'hB1);
        tick();
        check("starve_released", 32'(alu_stall), 32'd0);
        check("starve_count3", 32'(lq_count), 32'd3);
        alu_valid = 1'b0;
        push_exp(5'd12, 32'hB2);
        push_exp(5'd13, 32'hB3);
        push_exp(5'd14, 32'hB4);
        repeat (3) tick();
        check("starve_drained", 32'(lq_count), 32'd0);
        tick();

        // Hazard query against a queued load and the output register
        alu_valid = 1'b1;
        alu_rd    = 5'd9;
        alu_data  = 32'h99;
        lsu_valid = 1'b1;
        lsu_rd    = 5'd7;
        lsu_data  = 32'h77;
        chk_addr  = 5'd7;
        #1;
        check("chk_no_bypass", 32'(chk_pending), 32'd0);
        push_exp(5'd9, 32'h99);
        tick();
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        #1;
        check("chk_queued", 32'(chk_pending), 32'd1);
        chk_addr = 5'd0;
        #1;
        check("chk_x0", 32'(chk_pending), 32'd0);
        chk_addr = 5'd8;
        #1;
        check("chk_other", 32'(chk_pending), 32'd0);
        chk_addr = 5'd7;
        push_exp(5'd7, 32'h77);
        tick();
        check("chk_outreg", 32'(chk_pending), 32'd1);
        tick();
        check("chk_cleared", 32'(chk_pending), 32'd0);

        // Reset with loads queued drops them without a write
        alu_valid = 1'b1;
        alu_rd    = 5'd9;
        alu_data  = 32'h9A;
        lsu_valid = 1'b1;
        lsu_rd    = 5'd20;
        lsu_data  = 32'h20;
        push_exp(5'd9, 32'h9A);
        tick();
        alu_data = 32'h9B;
        lsu_rd   = 5'd21;
        lsu_data = 32'h21;
        push_exp(5'd9, 32'h9B);
        tick();
        check("pre_rst_count", 32'(lq_count), 32'd2);
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        reset_n   = 1'b0;
        chk_addr  = 5'd20;
        tick();
        check("mid_rst_count", 32'(lq_count), 32'd0);
        check("mid_rst_wen", 32'(rf_write_en), 32'd0);
        check("mid_rst_chk", 32'(chk_pending), 32'd0);
        reset_n = 1'b1;
        repeat (3) tick();
        check("post_rst_count", 32'(lq_count), 32'd0);
        check("post_rst_wen", 32'(rf_write_en), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
